// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: write-back port arbiter (pipeline vs long-latency) with starvation guard; WB_ZERO_FILTER_EN drops $0 writes
module wb_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_wen,
  input  logic              pipe_jal,
  input  logic [4:0]        pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lr_valid,
  input  logic [4:0]        lr_reg,
  input  logic [DATA_W-1:0] lr_data,
  output logic              lr_ready,
  output logic              pipe_stall,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {ARB, FORCE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] starve_cnt, cnt_nxt;
  logic pipe_grant, lr_grant, wr;
  logic [4:0] waddr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  // lr is withheld during reset so no result is consumed without being written
  always_comb begin
    pipe_grant = state == ARB && pipe_wen;
    lr_grant = !reset && !pipe_grant;
    lr_ready = lr_valid && lr_grant;
    wr = pipe_grant || lr_ready;
    waddr_nxt = pipe_grant ? (pipe_jal ? 5'd31 : pipe_reg) : lr_reg;
    wdata_nxt = pipe_grant ? pipe_data : lr_data;
    cnt_nxt = (state == ARB && pipe_wen && lr_valid) ? starve_cnt + 1'b1 : '0;
    state_nxt = (state == ARB && cnt_nxt == CW'(STARVE_LIMIT)) ? FORCE : ARB;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB;
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
      rf_wen <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state <= state_nxt;
      starve_cnt <= state_nxt == FORCE ? '0 : cnt_nxt;
      pipe_stall <= state_nxt == FORCE;
`ifdef WB_ZERO_FILTER_EN
      rf_wen <= wr && waddr_nxt != 5'd0;
`else
      rf_wen <= wr;
`endif
      if (wr) begin
        rf_waddr <= waddr_nxt;
        rf_wdata <= wdata_nxt;
      end
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed vectors plus a per-cycle behavioural model of the write-back arbiter
module tb_wb_write_arbiter;
  localparam int SL = 4;
  localparam int DW = 32;
  logic clock = 0, reset = 1, pipe_wen = 0, pipe_jal = 0, lr_valid = 0;
  logic [4:0] pipe_reg = 0, lr_reg = 0;
  logic [DW-1:0] pipe_data = 0, lr_data = 0;
  logic lr_ready, pipe_stall, rf_wen;
  logic [4:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  wb_write_arbiter #(.STARVE_LIMIT(SL), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .pipe_wen(pipe_wen), .pipe_jal(pipe_jal),
    .pipe_reg(pipe_reg), .pipe_data(pipe_data), .lr_valid(lr_valid), .lr_reg(lr_reg),
    .lr_data(lr_data), .lr_ready(lr_ready), .pipe_stall(pipe_stall), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: lr wins whenever the pipe is idle or the cycle is a forced one;
  // m_lose counts consecutive contested losses, hitting SL forces the next cycle.
  bit m_init = 0, m_forced = 0, pipe_wins, lr_wins;
  int m_lose = 0;
  logic e_wen = 0, e_stall = 0;
  logic [4:0] e_addr = 0, dest;
  logic [DW-1:0] e_data = 0;
  always @(posedge clock) begin
    if (reset) begin
      m_forced = 0; m_lose = 0; e_wen = 0; e_addr = 0; e_data = 0; e_stall = 0;
    end else begin
      pipe_wins = !m_forced && pipe_wen;
      lr_wins = !pipe_wins && lr_valid;
      dest = pipe_wins ? (pipe_jal ? 5'd31 : pipe_reg) : lr_reg;
`ifdef WB_ZERO_FILTER_EN
      e_wen = (pipe_wins || lr_wins) && dest != 0;
`else
      e_wen = pipe_wins || lr_wins;
`endif
      if (pipe_wins || lr_wins) begin
        e_addr = dest;
        e_data = pipe_wins ? pipe_data : lr_data;
      end
      m_lose = (!m_forced && pipe_wen && lr_valid) ? m_lose + 1 : 0;
      m_forced = m_lose == SL;
      if (m_forced) m_lose = 0;
      e_stall = m_forced;
    end
    m_init = 1;
  end
  always @(negedge clock) if (m_init) begin
    chk("m_rf_wen", rf_wen, e_wen);
    chk("m_rf_waddr", rf_waddr, e_addr);
    chk("m_rf_wdata", rf_wdata, e_data);
    chk("m_pipe_stall", pipe_stall, e_stall);
    chk("m_lr_ready", lr_ready, !reset && lr_valid && (m_forced || !pipe_wen));
  end
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask
  task automatic contend_to_force();
    pipe_wen = 1; pipe_jal = 0; pipe_reg = 3; pipe_data = 32'h0000_0333;
    lr_valid = 1; lr_reg = 9; lr_data = 32'h0000_BEEF;
    for (int i = 0; i < SL; i++) begin
      #1 chk("contest_ready", lr_ready, 0);
      chk("contest_stall", pipe_stall, 0);
      cyc();
    end
  endtask
  initial begin
    repeat (2) cyc();
    chk("reset_wen", rf_wen, 0);
    chk("reset_addr", rf_waddr, 0);
    chk("reset_stall", pipe_stall, 0);
    reset = 0;
    pipe_wen = 1; pipe_jal = 1; pipe_reg = 16; pipe_data = 32'h0040_0008;
    cyc();
    chk("jal_wen", rf_wen, 1);
    chk("jal_addr", rf_waddr, 31);
    chk("jal_data", rf_wdata, 32'h0040_0008);
    pipe_wen = 0; pipe_jal = 1;
    lr_valid = 1; lr_reg = 5; lr_data = 32'h0000_1234;
    #1 chk("lr_ready_idle", lr_ready, 1);
    cyc();
    chk("lr_wen", rf_wen, 1);
    chk("lr_addr", rf_waddr, 5);
    chk("lr_data", rf_wdata, 32'h0000_1234);
    lr_valid = 0; pipe_wen = 1; pipe_jal = 0; pipe_reg = 7; pipe_data = 32'h0000_0777;
    cyc();
    chk("w7_addr", rf_waddr, 7);
    pipe_wen = 0;
    repeat (2) begin
      cyc();
      chk("idle_wen", rf_wen, 0);
      chk("idle_addr", rf_waddr, 7);
      chk("idle_data", rf_wdata, 32'h0000_0777);
    end
    pipe_wen = 1; pipe_reg = 0; pipe_data = 32'h0000_DEAD;
    cyc();
`ifdef WB_ZERO_FILTER_EN
    chk("zero_wen", rf_wen, 0);
`else
    chk("zero_wen", rf_wen, 1);
    chk("zero_addr", rf_waddr, 0);
`endif
    contend_to_force();
    chk("force_stall", pipe_stall, 1);
    chk("force_ready", lr_ready, 1);
    chk("force_prev_pipe", rf_waddr, 3);
    cyc();
    chk("force_lr_addr", rf_waddr, 9);
    chk("force_lr_data", rf_wdata, 32'h0000_BEEF);
    chk("force_stall_drop", pipe_stall, 0);
    lr_valid = 0;
    cyc();
    chk("resume_addr", rf_waddr, 3);
    chk("resume_wen", rf_wen, 1);
    contend_to_force();
    chk("force2_stall", pipe_stall, 1);
    reset = 1;
    #1 chk("rst_force_ready", lr_ready, 0);
    cyc();
    reset = 0;
    chk("rst_force_stall", pipe_stall, 0);
    chk("rst_force_wen", rf_wen, 0);
    #1 chk("rst_after_ready", lr_ready, 0);
    cyc();
    chk("rst_after_stall", pipe_stall, 0);
    pipe_wen = 0;
    #1 chk("rst_lr_ready", lr_ready, 1);
    cyc();
    chk("rst_lr_addr", rf_waddr, 9);
    lr_valid = 0;
    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
